// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial unsigned subtractor. Computes a - b modulo 2^WIDTH, LSB first,
// one bit per clock, with a one-bit full-subtractor cell and a borrow
// flip-flop. A three-state FSM (IDLE -> SHIFT -> DONE -> IDLE) sequences one
// operation: WIDTH cycles of SHIFT, then a single DONE cycle in which the
// result outputs are freshly valid.
//
// Ports
//   clk        in   1      clock, all state updates on the rising edge
//   rst        in   1      synchronous, active-high reset
//   start      in   1      begin a subtraction (only looked at in IDLE)
//   a          in   WIDTH  minuend, captured on the accepting edge
//   b          in   WIDTH  subtrahend, captured on the accepting edge
//   busy       out  1      high while in SHIFT
//   done       out  1      one-cycle pulse while in DONE
//   diff       out  WIDTH  a - b modulo 2^WIDTH, held until the next DONE
//   borrow_out out  1      final borrow (1 iff a < b unsigned), held
//   zero       out  1      1 iff diff == 0, held
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero
);

  // Counter must represent WIDTH itself so it can never wrap mid-operation.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow_out;
  logic             r_zero;

  // One-bit full-subtractor cell on the current operand LSBs.
  logic             w_ab_xor;
  logic             w_d;
  logic             w_bout;
  logic [WIDTH-1:0] w_res_next;
  logic             w_last;

  assign w_ab_xor   = r_a[0] ^ r_b[0];
  assign w_d        = w_ab_xor ^ r_borrow;
  assign w_bout     = (~r_a[0] & r_b[0]) | (~w_ab_xor & r_borrow);
  // Result fills from the MSB side so after WIDTH shifts bit 0 sits at LSB.
  assign w_res_next = {w_d, r_res[WIDTH-1:1]};
  assign w_last     = (r_cnt == LAST_BIT);

  // Next-state and state-decoded outputs.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; that is what keeps this block from inferring latches.
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_next = S_SHIFT;
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register and datapath.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      r_state      <= S_IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_res        <= '0;
      r_borrow     <= 1'b0;
      r_cnt        <= '0;
      r_diff       <= '0;
      r_borrow_out <= 1'b0;
      r_zero       <= 1'b1;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
          end
        end
        S_SHIFT: begin
          r_a      <= r_a >> 1;
          r_b      <= r_b >> 1;
          r_res    <= w_res_next;
          r_borrow <= w_bout;
          r_cnt    <= r_cnt + CW'(1);
          // Outputs are loaded on the edge that enters DONE, using the
          // final bit's cell outputs directly.
          if (w_last) begin
            r_diff       <= w_res_next;
            r_borrow_out <= w_bout;
            r_zero       <= (w_res_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign diff       = r_diff;
  assign borrow_out = r_borrow_out;
  assign zero       = r_zero;

endmodule
